// File: rtl/except_ctrl_pkg.sv
// Shared definitions for the exception controller: exception flag indices,
// ExceptBus codes, CP0 field positions, vector offsets and FSM encoding.
package except_ctrl_pkg;

  localparam int EXC_W = 11;

  localparam int EXC_MCHECK   = 0;
  localparam int EXC_ADEL     = 1;
  localparam int EXC_TLBL     = 2;
  localparam int EXC_RI       = 3;
  localparam int EXC_SYSCALL  = 4;
  localparam int EXC_TRAP     = 5;
  localparam int EXC_OVERFLOW = 6;
  localparam int EXC_ADES     = 7;
  localparam int EXC_TLBS     = 8;
  localparam int EXC_MOD      = 9;
  localparam int EXC_ERET     = 10;

  localparam logic [31:0] ZERO_WORD     = 32'h0000_0000;
  localparam logic [31:0] INTERRUPT_EXP = 32'h0000_0001;
  localparam logic [31:0] TLBL_EXP      = 32'h0000_0002;
  localparam logic [31:0] TLBS_EXP      = 32'h0000_0003;
  localparam logic [31:0] ADEL_EXP      = 32'h0000_0004;
  localparam logic [31:0] ADES_EXP      = 32'h0000_0005;
  localparam logic [31:0] SYSCALL_EXP   = 32'h0000_0008;
  localparam logic [31:0] RI_EXP        = 32'h0000_000a;
  localparam logic [31:0] OVERFLOW_EXP  = 32'h0000_000c;
  localparam logic [31:0] TRAP_EXP      = 32'h0000_000d;
  localparam logic [31:0] ERET_EXP      = 32'h0000_000e;
  localparam logic [31:0] MOD_EXP       = 32'h0000_0011;
  localparam logic [31:0] MCHECK_EXP    = 32'h0000_0018;

  localparam int ST_IE    = 0;
  localparam int ST_EXL   = 1;
  localparam int ST_ERL   = 2;
  localparam int ST_BEV   = 22;
  localparam int CAUSE_IV = 23;

  localparam logic [11:0] OFF_TLB_REFILL = 12'h000;
  localparam logic [11:0] OFF_GENERAL    = 12'h180;
  localparam logic [11:0] OFF_INT_IV     = 12'h200;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_COMMIT   = 2'd1,
    S_REDIRECT = 2'd2,
    S_HOLD     = 2'd3
  } state_e;

  function automatic logic [31:0] exc_code(input int idx);
    logic [31:0] code;
    case (idx)
      EXC_MCHECK:   code = MCHECK_EXP;
      EXC_ADEL:     code = ADEL_EXP;
      EXC_TLBL:     code = TLBL_EXP;
      EXC_RI:       code = RI_EXP;
      EXC_SYSCALL:  code = SYSCALL_EXP;
      EXC_TRAP:     code = TRAP_EXP;
      EXC_OVERFLOW: code = OVERFLOW_EXP;
      EXC_ADES:     code = ADES_EXP;
      EXC_TLBS:     code = TLBS_EXP;
      EXC_MOD:      code = MOD_EXP;
      EXC_ERET:     code = ERET_EXP;
      default:      code = ZERO_WORD;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/except_ctrl_prio_enc.sv
// Fixed-priority selection of one exception for the MEM-stage instruction,
// producing its ExceptBus code and vector offset.
module except_prio_enc
  import except_ctrl_pkg::*;
(
  input  logic [EXC_W-1:0] exc_i,
  input  logic             int_pending_i,
  input  logic             exl_i,
  input  logic             iv_i,
  output logic             valid_o,
  output logic [31:0]      code_o,
  output logic [11:0]      offset_o
);

  always_comb begin
    valid_o  = int_pending_i | (|exc_i);
    code_o   = ZERO_WORD;
    offset_o = OFF_GENERAL;
    // Scan lowest priority first so the highest-priority flag is written last.
    for (int i = EXC_W - 1; i >= 0; i--) begin
      if (exc_i[i]) code_o = exc_code(i);
    end
    if (int_pending_i) begin
      code_o   = INTERRUPT_EXP;
      offset_o = iv_i ? OFF_INT_IV : OFF_GENERAL;
    end else if ((code_o == TLBL_EXP || code_o == TLBS_EXP) && !exl_i) begin
      offset_o = OFF_TLB_REFILL;
    end
  end

endmodule

// File: rtl/except_ctrl.sv
// Exception/interrupt controller: synchronizes interrupt lines, picks one
// exception per MEM instruction and sequences CP0 commit, flush and redirect.
module except_ctrl
  import except_ctrl_pkg::*;
#(
  parameter int unsigned  FLUSH_CYCLES  = 3,
  parameter logic [31:0]  RESET_VEC_BEV = 32'hBFC0_0200
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       int_i,
  input  logic             mem_valid_i,
  input  logic [EXC_W-1:0] mem_exc_i,
  input  logic [31:0]      mem_pc_i,
  input  logic             mem_in_delayslot_i,
  input  logic [31:0]      mem_badaddr_i,
  input  logic [31:0]      cp0_status_i,
  input  logic [31:0]      cp0_cause_i,
  input  logic [31:0]      cp0_epc_i,
  input  logic [31:0]      cp0_ebase_i,
  output logic [5:0]       int_sync_o,
  output logic [31:0]      excepttype_o,
  output logic [31:0]      current_inst_addr_o,
  output logic [31:0]      badaddr_o,
  output logic             is_in_delayslot_o,
  output logic             mem_kill_o,
  output logic             flush_o,
  output logic [31:0]      new_pc_o,
  output logic             busy_o
);

  localparam logic [3:0] HOLD_LOAD = 4'(FLUSH_CYCLES);

  logic [5:0]  sync1_q, sync2_q;
  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] type_q, type_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] bad_q, bad_d;
  logic        ds_q, ds_d;
  logic [11:0] off_q, off_d;

  logic        int_pending;
  logic        enc_valid;
  logic [31:0] enc_code;
  logic [11:0] enc_offset;
  logic        candidate;
  logic [31:0] vec_base;
  logic        unused_bits;

  assign unused_bits = ^{cp0_cause_i[31:24], cp0_cause_i[22:16], cp0_cause_i[7:0],
                         cp0_ebase_i[11:0]};

  assign int_pending = cp0_status_i[ST_IE] & ~cp0_status_i[ST_EXL] & ~cp0_status_i[ST_ERL]
                       & (|(cp0_cause_i[15:8] & cp0_status_i[15:8]));

  except_prio_enc u_prio_enc (
    .exc_i         (mem_exc_i),
    .int_pending_i (int_pending),
    .exl_i         (cp0_status_i[ST_EXL]),
    .iv_i          (cp0_cause_i[CAUSE_IV]),
    .valid_o       (enc_valid),
    .code_o        (enc_code),
    .offset_o      (enc_offset)
  );

  assign candidate = mem_valid_i & enc_valid;
  assign vec_base  = cp0_status_i[ST_BEV] ? RESET_VEC_BEV : {cp0_ebase_i[31:12], 12'h000};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      state_q <= S_IDLE;
      cnt_q   <= '0;
      type_q  <= ZERO_WORD;
      pc_q    <= '0;
      bad_q   <= '0;
      ds_q    <= 1'b0;
      off_q   <= '0;
    end else begin
      sync1_q <= int_i;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      type_q  <= type_d;
      pc_q    <= pc_d;
      bad_q   <= bad_d;
      ds_q    <= ds_d;
      off_q   <= off_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    type_d  = type_q;
    pc_d    = pc_q;
    bad_d   = bad_q;
    ds_d    = ds_q;
    off_d   = off_q;
    case (state_q)
      S_IDLE: begin
        if (candidate) begin
          state_d = S_COMMIT;
          type_d  = enc_code;
          pc_d    = mem_pc_i;
          bad_d   = mem_badaddr_i;
          ds_d    = mem_in_delayslot_i;
          off_d   = enc_offset;
        end
      end
      S_COMMIT:   state_d = S_REDIRECT;
      S_REDIRECT: begin
        state_d = S_HOLD;
        cnt_d   = HOLD_LOAD;
      end
      S_HOLD: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    int_sync_o          = sync2_q;
    busy_o              = (state_q != S_IDLE);
    mem_kill_o          = (state_q == S_IDLE) & candidate & ~rst;
    excepttype_o        = ZERO_WORD;
    current_inst_addr_o = '0;
    badaddr_o           = '0;
    is_in_delayslot_o   = 1'b0;
    flush_o             = 1'b0;
    new_pc_o            = '0;
    if (state_q == S_COMMIT) begin
      excepttype_o        = type_q;
      current_inst_addr_o = pc_q;
      badaddr_o           = bad_q;
      is_in_delayslot_o   = ds_q;
    end
    // EPC is read live here: CP0 has had a cycle to settle after COMMIT.
    if (state_q == S_REDIRECT) begin
      flush_o  = 1'b1;
      new_pc_o = (type_q == ERET_EXP) ? cp0_epc_i : (vec_base | {20'h0, off_q});
    end
  end

endmodule

// File: tb/tb_except_ctrl.sv
// Self-checking bench for except_ctrl: directed vector table, hand-written
// corner sequences and randomized transactions against a reference model.
module tb_except_ctrl;

  localparam logic [31:0] C_INT = 32'h01, C_TLBL = 32'h02, C_TLBS = 32'h03, C_ADEL = 32'h04;
  localparam logic [31:0] C_ADES = 32'h05, C_SYS = 32'h08, C_RI = 32'h0a, C_OVF = 32'h0c;
  localparam logic [31:0] C_TRAP = 32'h0d, C_ERET = 32'h0e, C_MOD = 32'h11, C_MCHK = 32'h18;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  int_i = '0;
  logic        mem_valid = 1'b0;
  logic [10:0] mem_exc = '0;
  logic [31:0] mem_pc = '0, mem_bad = '0;
  logic        mem_ds = 1'b0;
  logic [31:0] status = '0, cause = '0, epc = '0, ebase = '0;

  logic [5:0]  int_sync_o;
  logic [31:0] excepttype_o, current_inst_addr_o, badaddr_o, new_pc_o;
  logic        is_in_delayslot_o, mem_kill_o, flush_o, busy_o;

  int n_checks = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  except_ctrl #(.FLUSH_CYCLES(3), .RESET_VEC_BEV(32'hBFC0_0200)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .int_i               (int_i),
    .mem_valid_i         (mem_valid),
    .mem_exc_i           (mem_exc),
    .mem_pc_i            (mem_pc),
    .mem_in_delayslot_i  (mem_ds),
    .mem_badaddr_i       (mem_bad),
    .cp0_status_i        (status),
    .cp0_cause_i         (cause),
    .cp0_epc_i           (epc),
    .cp0_ebase_i         (ebase),
    .int_sync_o          (int_sync_o),
    .excepttype_o        (excepttype_o),
    .current_inst_addr_o (current_inst_addr_o),
    .badaddr_o           (badaddr_o),
    .is_in_delayslot_o   (is_in_delayslot_o),
    .mem_kill_o          (mem_kill_o),
    .flush_o             (flush_o),
    .new_pc_o            (new_pc_o),
    .busy_o              (busy_o)
  );

  typedef struct {
    logic [31:0] status, cause, ebase, epc;
    logic [10:0] exc;
    logic [31:0] pc, bad;
    logic        ds;
    logic        exp_cand;
    logic [31:0] exp_code, exp_pc;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  // Reference model: rule-based, from priority list and vector rules.
  function automatic void model(inout vec_t v);
    logic [31:0] codes [12];
    logic        flags [12];
    logic        intp;
    int          win;
    logic [31:0] base;
    logic [11:0] off;
    codes = '{C_INT, C_MCHK, C_ADEL, C_TLBL, C_RI, C_SYS, C_TRAP, C_OVF, C_ADES, C_TLBS, C_MOD, C_ERET};
    intp = v.status[0] && !v.status[1] && !v.status[2] && ((v.cause[15:8] & v.status[15:8]) != 8'h0);
    flags[0] = intp;
    for (int k = 0; k < 11; k++) flags[k+1] = v.exc[k];
    win = -1;
    for (int k = 11; k >= 0; k--) if (flags[k]) win = k;
    v.exp_cand = (win >= 0);
    v.exp_code = (win >= 0) ? codes[win] : 32'h0;
    base = v.status[22] ? 32'hBFC0_0200 : (v.ebase & 32'hFFFF_F000);
    if ((v.exp_code == C_TLBL || v.exp_code == C_TLBS) && !v.status[1]) off = 12'h000;
    else if (v.exp_code == C_INT && v.cause[23]) off = 12'h200;
    else off = 12'h180;
    v.exp_pc = (v.exp_code == C_ERET) ? v.epc : (base | {20'h0, off});
  endfunction

  task automatic drive(input vec_t v);
    status = v.status; cause = v.cause; ebase = v.ebase; epc = v.epc;
    mem_exc = v.exc; mem_pc = v.pc; mem_bad = v.bad; mem_ds = v.ds;
    mem_valid = 1'b1;
  endtask

  task automatic run_txn(input vec_t v, input string tag);
    int n;
    @(negedge clk);
    drive(v);
    #1;
    check({tag, " kill"}, mem_kill_o, 32'(v.exp_cand));
    if (!v.exp_cand) begin
      @(negedge clk);
      mem_valid = 1'b0; mem_exc = '0;
      check({tag, " idle_busy"}, busy_o, 0);
      return;
    end
    @(negedge clk);
    mem_valid = 1'b0; mem_exc = '0;
    check({tag, " code"}, excepttype_o, v.exp_code);
    check({tag, " addr"}, current_inst_addr_o, v.pc);
    check({tag, " bad"}, badaddr_o, v.bad);
    check({tag, " ds"}, is_in_delayslot_o, 32'(v.ds));
    check({tag, " commit_flush"}, flush_o, 0);
    @(negedge clk);
    check({tag, " flush"}, flush_o, 1);
    check({tag, " new_pc"}, new_pc_o, v.exp_pc);
    check({tag, " code_gone"}, excepttype_o, 0);
    n = 0;
    @(negedge clk);
    while (busy_o === 1'b1 && n < 20) begin
      check({tag, " hold_flush"}, flush_o, 0);
      n++;
      @(negedge clk);
    end
    check({tag, " hold_cycles"}, n, 3);
    $display("txn %s code=%h new_pc=%h hold=%0d", tag, v.exp_code, v.exp_pc, n);
  endtask

  vec_t tbl [10];

  initial begin
    vec_t v;
    int   n;
    //               status        cause         ebase         epc           exc       pc            bad           ds   cand code     pc
    tbl[0] = '{32'h0000_FF01, 32'h0000_0400, 32'h8000_0000, 32'h0,        11'h000, 32'h8000_1000, 32'h0,        1'b0, 1'b1, C_INT,  32'h8000_0180};
    tbl[1] = '{32'h0000_0000, 32'h0,        32'h8000_0000, 32'h0,        11'h042, 32'h8000_0040, 32'h0000_0003, 1'b0, 1'b1, C_ADEL, 32'h8000_0180};
    tbl[2] = '{32'h0000_0000, 32'h0,        32'h8000_0000, 32'h0,        11'h004, 32'h8000_0100, 32'h1234_5678, 1'b0, 1'b1, C_TLBL, 32'h8000_0000};
    tbl[3] = '{32'h0000_0002, 32'h0,        32'h8000_0000, 32'h0,        11'h004, 32'h8000_0104, 32'h1234_567c, 1'b1, 1'b1, C_TLBL, 32'h8000_0180};
    tbl[4] = '{32'h0000_0002, 32'h0,        32'h8000_0000, 32'h8000_2004, 11'h400, 32'h8000_0200, 32'h0,        1'b0, 1'b1, C_ERET, 32'h8000_2004};
    tbl[5] = '{32'h0000_FF01, 32'h0080_0400, 32'h8000_0000, 32'h0,        11'h010, 32'h8000_0300, 32'h0,        1'b1, 1'b1, C_INT,  32'h8000_0200};
    tbl[6] = '{32'h0040_0000, 32'h0,        32'h8000_0000, 32'h0,        11'h008, 32'h8000_0400, 32'h0,        1'b0, 1'b1, C_RI,   32'hBFC0_0380};
    tbl[7] = '{32'h0000_0000, 32'h0,        32'h9000_0ABC, 32'h0,        11'h100, 32'h8000_0500, 32'hDEAD_0000, 1'b0, 1'b1, C_TLBS, 32'h9000_0000};
    tbl[8] = '{32'h0000_0000, 32'h0,        32'h8000_0000, 32'h0,        11'h401, 32'h8000_0600, 32'h0,        1'b0, 1'b1, C_MCHK, 32'h8000_0180};
    tbl[9] = '{32'h0000_FF03, 32'h0000_FF00, 32'h8000_0000, 32'h0,        11'h200, 32'h8000_0700, 32'h0,        1'b0, 1'b1, C_MOD,  32'h8000_0180};

    // Reset state, with a live request present during reset.
    mem_valid = 1'b1; mem_exc = 11'h010; int_i = 6'h3f;
    @(negedge clk); @(negedge clk);
    check("rst int_sync", int_sync_o, 0);
    check("rst kill", mem_kill_o, 0);
    check("rst busy", busy_o, 0);
    check("rst code", excepttype_o, 0);
    check("rst flush", flush_o, 0);
    check("rst new_pc", new_pc_o, 0);
    mem_valid = 1'b0; mem_exc = '0; int_i = '0;
    rst = 1'b0;

    // Interrupt synchronizer latency.
    @(negedge clk);
    int_i = 6'h01;
    @(negedge clk);
    check("sync after 1 edge", int_sync_o, 0);
    @(negedge clk);
    check("sync after 2 edges", int_sync_o, 6'h01);

    for (int i = 0; i < 10; i++) run_txn(tbl[i], $sformatf("tbl%0d", i));
    int_i = '0;

    // SYSCALL accepted, a second one during REDIRECT is dropped.
    v = '{32'h0, 32'h0, 32'h8000_0000, 32'h0, 11'h010, 32'h8000_0800, 32'h0, 1'b0, 1'b1, C_SYS, 32'h8000_0180};
    @(negedge clk);
    drive(v);
    #1 check("sys1 kill", mem_kill_o, 1);
    @(negedge clk);
    mem_valid = 1'b0; mem_exc = '0;
    check("sys1 code", excepttype_o, C_SYS);
    @(negedge clk);
    drive(v); mem_pc = 32'h8000_0804;
    #1 check("sys2 kill", mem_kill_o, 0);
    check("sys2 flush", flush_o, 1);
    n = 0;
    @(negedge clk);
    mem_valid = 1'b0; mem_exc = '0;
    while (busy_o === 1'b1 && n < 20) begin n++; @(negedge clk); end
    check("sys hold_cycles", n, 3);
    @(negedge clk);
    check("sys2 dropped busy", busy_o, 0);
    check("sys2 dropped code", excepttype_o, 0);
    $display("txn syscall-pair hold=%0d", n);

    // Reset asserted during REDIRECT.
    v = tbl[1];
    @(negedge clk);
    drive(v);
    @(negedge clk);
    mem_valid = 1'b0; mem_exc = '0;
    @(negedge clk);
    check("rstmid flush_before", flush_o, 1);
    rst = 1'b1; mem_valid = 1'b1; mem_exc = 11'h010;
    #1;
    check("rstmid flush", flush_o, 0);
    check("rstmid busy", busy_o, 0);
    check("rstmid code", excepttype_o, 0);
    check("rstmid new_pc", new_pc_o, 0);
    check("rstmid kill", mem_kill_o, 0);
    @(negedge clk);
    rst = 1'b0; mem_valid = 1'b0; mem_exc = '0;
    @(negedge clk);
    check("rstmid after busy", busy_o, 0);
    check("rstmid after flush", flush_o, 0);
    $display("txn reset-in-redirect");

    // Randomized transactions against the reference model.
    for (int r = 0; r < 80; r++) begin
      logic [31:0] rnd;
      rnd = $urandom();
      v.status = {9'h0, ($urandom_range(0, 3) == 0), 6'h0, rnd[15:8], 5'h0,
                  ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0), rnd[0]};
      rnd = $urandom();
      v.cause = {8'h0, rnd[23], 7'h0, ($urandom_range(0, 1) == 0) ? 8'h0 : rnd[15:8], 8'h0};
      v.ebase = $urandom();
      v.epc   = $urandom();
      v.pc    = $urandom();
      v.bad   = $urandom();
      v.ds    = 1'($urandom_range(0, 1));
      v.exc   = '0;
      n = $urandom_range(0, 2);
      for (int k = 0; k < n; k++) v.exc[$urandom_range(0, 10)] = 1'b1;
      model(v);
      if ($urandom_range(0, 4) == 0) begin
        v.exp_cand = 1'b0;
        @(negedge clk);
        drive(v); mem_valid = 1'b0;
        #1 check($sformatf("rnd%0d novalid kill", r), mem_kill_o, 0);
        @(negedge clk);
        check($sformatf("rnd%0d novalid busy", r), busy_o, 0);
        $display("txn rnd%0d mem_valid=0", r);
      end else begin
        run_txn(v, $sformatf("rnd%0d", r));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
